// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target: address match, byte receive and transmit with ACK handling
// Optional input glitch filter: I2C_TARGET_GLITCH_FILTER_EN
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_RX_BYTE   = 4'd3,
    S_RX_ACK    = 4'd4,
    S_TX_BYTE   = 4'd5,
    S_TX_ACK    = 4'd6,
    S_WAIT_STOP = 4'd7
  } state_t;

  state_t     r_state;
  logic [1:0] r_scl_sync, r_sda_sync;
  logic       r_scl_prev, r_sda_prev;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_sda_low;
  logic       w_scl, w_sda;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // A level is accepted only once three consecutive synchronized samples agree.
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_hold, r_sda_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_hold <= 1'b1;
      r_sda_hold <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_hold <= w_scl;
      r_sda_hold <= w_sda;
    end
  end

  assign w_scl = (r_scl_hist == {2{r_scl_sync[1]}}) ? r_scl_sync[1] : r_scl_hold;
  assign w_sda = (r_sda_hist == {2{r_sda_sync[1]}}) ? r_sda_sync[1] : r_sda_hold;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  assign sda   = r_sda_low ? 1'b0 : 1'bz;
  assign state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_sda_low  <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addressed  <= 1'b0;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_cnt     <= 4'd0;
        r_sda_low <= 1'b0;
        addressed <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_cnt     <= 4'd0;
        r_sda_low <= 1'b0;
        addressed <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            if (r_cnt == 4'd7) begin
              r_rw    <= w_sda;
              r_cnt   <= 4'd0;
              r_state <= (r_shift[6:0] == TARGET_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_ADDR_ACK: if (w_scl_rise) begin
            r_cnt  <= 4'd1;
            tx_req <= ~r_rw;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              r_sda_low <= 1'b1;
              addressed <= 1'b1;
            end else begin
              r_cnt <= 4'd0;
              if (r_rw) begin
                r_sda_low <= 1'b0;
                r_state   <= S_RX_BYTE;
              end else begin
                r_shift   <= tx_data;
                r_sda_low <= ~tx_data[7];
                r_state   <= S_TX_BYTE;
              end
            end
          end
          S_RX_BYTE: if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            if (r_cnt == 4'd7) begin
              rx_data  <= {r_shift[6:0], w_sda};
              rx_valid <= 1'b1;
              r_cnt    <= 4'd0;
              r_state  <= S_RX_ACK;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_RX_ACK: if (w_scl_rise) begin
            r_cnt <= 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              r_sda_low <= 1'b1;
            end else begin
              r_sda_low <= 1'b0;
              r_cnt     <= 4'd0;
              r_state   <= S_RX_BYTE;
            end
          end
          S_TX_BYTE: if (w_scl_rise) begin
            r_cnt <= r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              r_sda_low <= 1'b0;
              r_cnt     <= 4'd0;
              r_state   <= S_TX_ACK;
            end else if (r_cnt != 4'd0) begin
              r_shift   <= {r_shift[6:0], r_shift[7]};
              r_sda_low <= ~r_shift[6];
            end
          end
          S_TX_ACK: if (w_scl_rise) begin
            if (!w_sda) begin
              tx_req <= 1'b1;
              r_cnt  <= 4'd1;
            end else begin
              r_cnt   <= 4'd0;
              r_state <= S_WAIT_STOP;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            r_shift   <= tx_data;
            r_sda_low <= ~tx_data[7];
            r_cnt     <= 4'd0;
            r_state   <= S_TX_BYTE;
          end
          S_IDLE, S_WAIT_STOP: r_sda_low <= 1'b0;
          default: begin
            r_sda_low <= 1'b0;
            r_state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - self-checking bench for i2c_target
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addressed;
  logic [3:0] state;

  int n_vec = 0, n_err = 0, n_rx = 0, n_txreq = 0, n_tgt_low = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_src_q[$];
  logic [7:0] exp_tx_q[$];

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h2A)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .addressed(addressed), .state(state)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; tick(Q);
    scl = 1'b1;       tick(Q);
    m_sda_low = 1'b1; tick(Q);
    scl = 1'b0;       tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; tick(Q);
    scl = 1'b1;       tick(Q);
    m_sda_low = 1'b0; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; tick(Q);
    scl = 1'b1;     tick(2 * Q);
    scl = 1'b0;     tick(Q);
  endtask

  // one-clk scl low pulse in the middle of the high phase
  task automatic write_bit_glitch(input logic b);
    m_sda_low = ~b; tick(Q);
    scl = 1'b1;     tick(Q);
    scl = 1'b0;     tick(1);
    scl = 1'b1;     tick(Q - 1);
    scl = 1'b0;     tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; tick(Q);
    scl = 1'b1;       tick(Q);
    b = sda;          tick(Q);
    scl = 1'b0;       tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d);
    for (int k = 7; k >= 0; k--) write_bit(d[k]);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int k = 7; k >= 0; k--) begin
      read_bit(b);
      d[k] = b;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      n_rx++;
      if (exp_rx_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_unexpected: got rx_data %0h, expected no rx_valid", rx_data);
      end else begin
        check("rx_data", rx_data, exp_rx_q.pop_front());
      end
    end
    if (tx_req) begin
      n_txreq++;
      if (tx_src_q.size() != 0) tx_data = tx_src_q.pop_front();
    end
    if (!reset && sda === 1'b0 && !m_sda_low) n_tgt_low++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  wr_vec_t vecs[6];

  initial begin
    int rx0, low0, tr0;
    logic ack;
    logic [7:0] b;
    logic [7:0] d;

    vecs[0] = '{7'h2A, 8'h5C, 1'b1};
    vecs[1] = '{7'h2A, 8'h00, 1'b1};
    vecs[2] = '{7'h2A, 8'hFF, 1'b1};
    vecs[3] = '{7'h2B, 8'h5C, 1'b0};
    vecs[4] = '{7'h2A, 8'hA5, 1'b1};
    vecs[5] = '{7'h15, 8'h3C, 1'b0};

    tick(3);
    check("reset_state", state, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_req", tx_req, 0);
    check("reset_addressed", addressed, 0);
    check("reset_sda", sda, 1);
    reset = 1'b0;
    tick(4);

    for (int i = 0; i < 6; i++) begin
      rx0  = n_rx;
      low0 = n_tgt_low;
      if (vecs[i].exp_ack) exp_rx_q.push_back(vecs[i].data);
      i2c_start();
      write_byte({vecs[i].addr, 1'b1});
      read_bit(ack);
      check("addr_ack", ack, !vecs[i].exp_ack);
      check("addressed", addressed, vecs[i].exp_ack);
      write_byte(vecs[i].data);
      read_bit(ack);
      check("data_ack", ack, !vecs[i].exp_ack);
      i2c_stop();
      tick(Q);
      check("idle_after_stop", state, 0);
      check("addressed_after_stop", addressed, 0);
      check("rx_valid_count", n_rx - rx0, vecs[i].exp_ack);
      if (!vecs[i].exp_ack) check("no_drive_on_mismatch", n_tgt_low - low0, 0);
    end

    tr0 = n_txreq;
    tx_src_q.push_back(8'hA3); tx_src_q.push_back(8'h17);
    exp_tx_q.push_back(8'hA3); exp_tx_q.push_back(8'h17);
    i2c_start();
    write_byte({7'h2A, 1'b0});
    read_bit(ack);
    check("rd_addr_ack", ack, 0);
    read_byte(b);
    check("rd_byte0", b, exp_tx_q.pop_front());
    write_bit(1'b0);
    read_byte(b);
    check("rd_byte1", b, exp_tx_q.pop_front());
    write_bit(1'b1);
    check("rd_wait_stop", state, 7);
    check("rd_tx_req_count", n_txreq - tr0, 2);
    i2c_stop();
    tick(Q);
    check("rd_idle", state, 0);

    rx0 = n_rx;
    d = 8'h5C;
    i2c_start();
    write_byte({7'h2A, 1'b1});
    read_bit(ack);
    check("rs_addr_ack", ack, 0);
    for (int k = 7; k >= 4; k--) write_bit(d[k]);
    i2c_start();
    check("rs_state", state, 1);
    check("rs_no_rx", n_rx - rx0, 0);
    check("rs_addressed", addressed, 0);
    tx_src_q.push_back(8'h3C);
    exp_tx_q.push_back(8'h3C);
    write_byte({7'h2A, 1'b0});
    read_bit(ack);
    check("rs_rd_addr_ack", ack, 0);
    read_byte(b);
    check("rs_rd_byte", b, exp_tx_q.pop_front());
    write_bit(1'b1);
    i2c_stop();
    tick(Q);
    check("rs_idle", state, 0);

    i2c_start();
    write_byte({7'h2A, 1'b1});
    check("ack_state", state, 2);
    check("ack_drive", sda, 0);
    check("ack_addressed", addressed, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_sda", sda, 1);
    check("rst_state", state, 0);
    check("rst_addressed", addressed, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_data", rx_data, 0);
    tick(2);
    reset = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(4 * Q);
    check("rst_idle_wait", state, 0);

    rx0 = n_rx;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_rx_q.push_back(8'h5C);
`else
    // unfiltered, the glitch adds a rising edge that re-samples bit 7
    exp_rx_q.push_back(8'h2E);
`endif
    i2c_start();
    write_byte({7'h2A, 1'b1});
    read_bit(ack);
    check("gl_addr_ack", ack, 0);
    write_bit_glitch(d[7]);
    for (int k = 6; k >= 0; k--) write_bit(d[k]);
    read_bit(ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    check("gl_data_ack", ack, 0);
`endif
    i2c_stop();
    tick(Q);
    check("gl_rx_count", n_rx - rx0, 1);
    check("gl_idle", state, 0);

    check("rx_queue_drained", exp_rx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
